sha_multiblock_ctrl: RTL and testbench

//  Parametrised successor to the SHA-256 control FSM. Owns round and block counters internally (no external

---
 rtl/sha_ctrl_pkg.sv | 29 ++
 rtl/sha_multiblock_ctrl_if.sv | 48 ++++
 rtl/sha_ctrl_counters.sv | 58 +++++
 rtl/sha_multiblock_ctrl.sv | 142 ++++++++++++++
 tb/tb_sha_multiblock_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the multi-block SHA-256/224 controller and its datapath.
package sha_ctrl_pkg;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    WAIT   = 4'd2,
    PAD_HI = 4'd3,
    PAD_LO = 4'd4,
    CRST   = 4'd5,
    ROUND  = 4'd6,
    UPDATE = 4'd7,
    DONE   = 4'd8
  } state_e;

  // Initial hash values, word 0 in the least significant slot.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [7:0][31:0] SHA224_IV = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

endpackage

// File: rtl/sha_multiblock_ctrl_if.sv
// Control/status bundle between the SHA block controller and its message datapath.
// The mode_224 input exists only when SHA_CTRL_SHA224_EN is defined.
interface sha_multiblock_ctrl_if #(
  parameter int RND_W = 6,
  parameter int BLK_W = 16
) ();

  logic             start;
  logic [BLK_W-1:0] blocks_num;
  logic             data_valid;
`ifdef SHA_CTRL_SHA224_EN
  logic             mode_224;
`endif
  logic             padding_en;
  logic             core_rst;
  logic             core_en;
  logic             load_hash_val;
  logic             initial_hash_val;
  logic             load_blocks_num;
  logic             len_hi_lo_sel;
  logic             data_len_sel;
  logic [RND_W-1:0] round_idx;
  logic [BLK_W-1:0] blk_left;
  logic             iv_sel;
  logic             busy;
  logic             done;

  modport master (
    output start, blocks_num, data_valid,
`ifdef SHA_CTRL_SHA224_EN
    output mode_224,
`endif
    input  padding_en, core_rst, core_en, load_hash_val, initial_hash_val,
    input  load_blocks_num, len_hi_lo_sel, data_len_sel, round_idx, blk_left,
    input  iv_sel, busy, done
  );

  modport slave (
    input  start, blocks_num, data_valid,
`ifdef SHA_CTRL_SHA224_EN
    input  mode_224,
`endif
    output padding_en, core_rst, core_en, load_hash_val, initial_hash_val,
    output load_blocks_num, len_hi_lo_sel, data_len_sel, round_idx, blk_left,
    output iv_sel, busy, done
  );

endinterface

// File: rtl/sha_ctrl_counters.sv
// Round index and remaining-block counters with terminal-count flags for the SHA control FSM.
module sha_ctrl_counters #(
  parameter int ROUNDS = 64,
  parameter int RND_W  = 6,
  parameter int BLK_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rnd_clr_i,
  input  logic             rnd_inc_i,
  input  logic             blk_load_i,
  input  logic [BLK_W-1:0] blk_load_val_i,
  input  logic             blk_dec_i,
  output logic [RND_W-1:0] round_idx_o,
  output logic [BLK_W-1:0] blk_left_o,
  output logic             rnd_last_o,
  output logic             blk_last_o
);

  logic [RND_W-1:0] round_q, round_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  assign rnd_last_o = (round_q == RND_W'(ROUNDS - 1));
  assign blk_last_o = (blk_q == BLK_W'(1));

  always_comb begin
    round_d = round_q;
    if (rnd_clr_i) begin
      round_d = '0;
    end else if (rnd_inc_i) begin
      round_d = rnd_last_o ? '0 : round_q + RND_W'(1);
    end
  end

  // A zero-length request still carries one (padding-only) block.
  always_comb begin
    blk_d = blk_q;
    if (blk_load_i) begin
      blk_d = (blk_load_val_i == '0) ? BLK_W'(1) : blk_load_val_i;
    end else if (blk_dec_i && (blk_q > BLK_W'(1))) begin
      blk_d = blk_q - BLK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      round_q <= '0;
      blk_q   <= '0;
    end else begin
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  assign round_idx_o = round_q;
  assign blk_left_o  = blk_q;

endmodule

// File: rtl/sha_multiblock_ctrl.sv
// Multi-block SHA-256 control FSM: padding, length append, core rounds and hash update per block.
// Optional SHA-224 IV selection is enabled by defining SHA_CTRL_SHA224_EN.
module sha_multiblock_ctrl
  import sha_ctrl_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int RND_W  = $clog2(ROUNDS),
  parameter int BLK_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sha_multiblock_ctrl_if.slave  bus
);

  state_e state_q, state_d;

  logic             start_accept;
  logic             rnd_clr, rnd_inc, blk_dec;
  logic             rnd_last, blk_last;
  logic [RND_W-1:0] round_idx;
  logic [BLK_W-1:0] blk_left;

  assign start_accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign rnd_clr      = (state_q == CRST);
  assign rnd_inc      = (state_q == ROUND);
  assign blk_dec      = (state_q == UPDATE) && !blk_last;

  sha_ctrl_counters #(
    .ROUNDS (ROUNDS),
    .RND_W  (RND_W),
    .BLK_W  (BLK_W)
  ) u_counters (
    .clk            (clk),
    .rst            (rst),
    .rnd_clr_i      (rnd_clr),
    .rnd_inc_i      (rnd_inc),
    .blk_load_i     (start_accept),
    .blk_load_val_i (bus.blocks_num),
    .blk_dec_i      (blk_dec),
    .round_idx_o    (round_idx),
    .blk_left_o     (blk_left),
    .rnd_last_o     (rnd_last),
    .blk_last_o     (blk_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the final block gets the padding/length-word phase ahead of its rounds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (bus.data_valid) state_d = blk_last ? PAD_HI : CRST;
      PAD_HI:  state_d = PAD_LO;
      PAD_LO:  state_d = CRST;
      CRST:    state_d = ROUND;
      ROUND:   if (rnd_last) state_d = UPDATE;
      UPDATE:  state_d = blk_last ? DONE : WAIT;
      DONE:    state_d = bus.start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic padding_en, core_rst, core_en, load_hash_val, initial_hash_val;
  logic load_blocks_num, len_hi_lo_sel, data_len_sel, busy, done;

  always_comb begin
    padding_en       = 1'b0;
    core_rst         = 1'b0;
    core_en          = 1'b0;
    load_hash_val    = 1'b0;
    initial_hash_val = 1'b0;
    load_blocks_num  = 1'b0;
    len_hi_lo_sel    = 1'b0;
    data_len_sel     = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    unique case (state_q)
      IDLE: busy = 1'b0;
      LOAD: begin
        load_blocks_num  = 1'b1;
        initial_hash_val = 1'b1;
        load_hash_val    = 1'b1;
      end
      WAIT: ;
      PAD_HI: begin
        padding_en    = 1'b1;
        data_len_sel  = 1'b1;
        len_hi_lo_sel = 1'b1;
      end
      PAD_LO: begin
        padding_en   = 1'b1;
        data_len_sel = 1'b1;
      end
      CRST:   core_rst = 1'b1;
      ROUND:  core_en = 1'b1;
      UPDATE: load_hash_val = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

`ifdef SHA_CTRL_SHA224_EN
  logic iv_sel_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      iv_sel_q <= 1'b0;
    end else if (start_accept) begin
      iv_sel_q <= bus.mode_224;
    end
  end

  assign bus.iv_sel = iv_sel_q;
`else
  assign bus.iv_sel = 1'b0;
`endif

  assign bus.padding_en       = padding_en;
  assign bus.core_rst         = core_rst;
  assign bus.core_en          = core_en;
  assign bus.load_hash_val    = load_hash_val;
  assign bus.initial_hash_val = initial_hash_val;
  assign bus.load_blocks_num  = load_blocks_num;
  assign bus.len_hi_lo_sel    = len_hi_lo_sel;
  assign bus.data_len_sel     = data_len_sel;
  assign bus.round_idx        = round_idx;
  assign bus.blk_left         = blk_left;
  assign bus.busy             = busy;
  assign bus.done             = done;

endmodule

// File: tb/tb_sha_multiblock_ctrl.sv
// Directed bench for sha_multiblock_ctrl: one line per message, immediate-assertion checks.
module tb_sha_multiblock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sha_multiblock_ctrl_if #(.RND_W(6), .BLK_W(16)) bus ();

  sha_multiblock_ctrl #(.ROUNDS(64), .RND_W(6), .BLK_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [15:0] upd_blk [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] flags();
    return {bus.padding_en, bus.core_rst, bus.core_en, bus.load_hash_val, bus.initial_hash_val,
            bus.load_blocks_num, bus.len_hi_lo_sel, bus.data_len_sel, bus.iv_sel, bus.busy, bus.done};
  endfunction

  // Starts a message in the current cycle (T0) and follows it until the done pulse.
  task automatic run_msg(input logic [15:0] nblk, input int gap, input bit poke,
                         output int lat, output int n_core, output int n_core_early,
                         output int n_upd, output int n_pad, output int pad_upd,
                         output int n_init, output logic ld1, output logic iv1,
                         output logic pad_hi3);
    lat = -1; n_core = 0; n_core_early = 0; n_upd = 0; n_pad = 0; pad_upd = -1;
    n_init = 0; ld1 = 1'b0; iv1 = 1'b0; pad_hi3 = 1'b0;
    upd_blk.delete();
    bus.start      = 1'b1;
    bus.blocks_num = nblk;
    bus.data_valid = (gap == 0);
    for (int c = 1; c <= 2000 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        ld1 = bus.load_blocks_num;
        iv1 = bus.iv_sel;
      end
      if (c == 3) pad_hi3 = bus.padding_en && bus.len_hi_lo_sel;
      if (gap > 0 && c == gap + 1) bus.data_valid = 1'b1;
      if (poke && (c == 5 || c == 40)) bus.start = 1'b1;
      if (poke && (c == 6 || c == 41)) bus.start = 1'b0;
      if (bus.core_en) begin
        n_core++;
        if (c <= gap + 1) n_core_early++;
      end
      if (bus.initial_hash_val) n_init++;
      if (bus.load_hash_val && !bus.initial_hash_val) begin
        n_upd++;
        upd_blk.push_back(bus.blk_left);
      end
      if (bus.padding_en) begin
        n_pad++;
        pad_upd = n_upd;
      end
      if (bus.done) lat = c;
    end
    $display("msg blocks=%0d gap=%0d latency=%0d rounds=%0d updates=%0d pads=%0d",
             nblk, gap, lat, n_core, n_upd, n_pad);
  endtask

  int   lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init;
  logic ld1, iv1, pad_hi3;
  int   hit;

  initial begin
    bus.start      = 1'b0;
    bus.blocks_num = '0;
    bus.data_valid = 1'b0;
`ifdef SHA_CTRL_SHA224_EN
    bus.mode_224   = 1'b0;
`endif

    // Reset for two cycles: everything zero.
    repeat (2) @(negedge clk);
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_round", 32'(bus.round_idx), 32'h0);
    check("rst_blk", 32'(bus.blk_left), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_flags", 32'(flags()), 32'h0);

    // One block, data ready on WAIT entry.
    run_msg(16'd1, 0, 1'b0, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("b1_latency", 32'(lat), 32'd71);
    check("b1_core_en", 32'(n_core), 32'd64);
    check("b1_updates", 32'(n_upd), 32'd1);
    check("b1_pad", 32'(n_pad), 32'd2);
    check("b1_padhi_t3", 32'(pad_hi3), 32'd1);
    check("b1_load_t1", 32'(ld1), 32'd1);
    check("b1_init", 32'(n_init), 32'd1);
    check("b1_iv", 32'(iv1), 32'd0);
    @(negedge clk);
    check("b1_done_once", 32'(bus.done), 32'd0);
    check("b1_idle_busy", 32'(bus.busy), 32'd0);

    // Three blocks: blk_left 3,2,1 at each update, padding only ahead of block 3.
    run_msg(16'd3, 0, 1'b0, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("b3_latency", 32'(lat), 32'd205);
    check("b3_core_en", 32'(n_core), 32'd192);
    check("b3_updates", 32'(n_upd), 32'd3);
    check("b3_pad", 32'(n_pad), 32'd2);
    check("b3_pad_block", 32'(pad_upd), 32'd2);
    check("b3_init", 32'(n_init), 32'd1);
    if (upd_blk.size() == 3) begin
      check("b3_blk0", 32'(upd_blk[0]), 32'd3);
      check("b3_blk1", 32'(upd_blk[1]), 32'd2);
      check("b3_blk2", 32'(upd_blk[2]), 32'd1);
    end else begin
      check("b3_blk_count", 32'(upd_blk.size()), 32'd3);
    end
    @(negedge clk);

    // Zero-length request acts as one block.
    run_msg(16'd0, 0, 1'b0, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("b0_latency", 32'(lat), 32'd71);
    check("b0_updates", 32'(n_upd), 32'd1);
    check("b0_pad", 32'(n_pad), 32'd2);
    check("b0_padhi_t3", 32'(pad_hi3), 32'd1);
    @(negedge clk);

    // data_valid withheld for 10 WAIT cycles, start pulses while busy.
    run_msg(16'd1, 10, 1'b1, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("stall_latency", 32'(lat), 32'd80);
    check("stall_core_early", 32'(n_core_early), 32'd0);
    check("stall_updates", 32'(n_upd), 32'd1);
    check("stall_init", 32'(n_init), 32'd1);
    @(negedge clk);
    check("stall_idle", 32'(flags()), 32'h0);

    // Reset mid-round, then a clean full message.
    bus.start = 1'b1;
    bus.blocks_num = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && hit == 0; c++) begin
      if (bus.round_idx == 6'd30) hit = 1;
      else @(negedge clk);
    end
    check("mid_reached_r30", 32'(hit), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_flags", 32'(flags()), 32'h0);
    check("mid_rst_round", 32'(bus.round_idx), 32'h0);
    check("mid_rst_blk", 32'(bus.blk_left), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    run_msg(16'd1, 0, 1'b0, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("post_rst_latency", 32'(lat), 32'd71);
    check("post_rst_updates", 32'(n_upd), 32'd1);

    // Back-to-back: start in DONE goes straight to LOAD.
`ifdef SHA_CTRL_SHA224_EN
    bus.mode_224 = 1'b1;
`endif
    run_msg(16'd2, 0, 1'b0, lat, n_core, n_core_early, n_upd, n_pad, pad_upd, n_init, ld1, iv1, pad_hi3);
    check("b2b_load_t1", 32'(ld1), 32'd1);
    check("b2b_latency", 32'(lat), 32'd138);
    check("b2b_updates", 32'(n_upd), 32'd2);
`ifdef SHA_CTRL_SHA224_EN
    check("b2b_iv224", 32'(iv1), 32'd1);
`else
    check("b2b_iv", 32'(iv1), 32'd0);
`endif
    @(negedge clk);
    check("end_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
